ibex_wb_bridge: RTL and testbench
=================================

IBEX_WB_BRIDGE -- requirements
Module: ibex_wb_bridge

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 255, max cycles a transaction may hold wb_cyc before forced error completion (range 1..65535).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 data_req_i  input  1  Ibex LSU request.
REQ-005 data_gnt_o  output  1  request accepted and captured.
REQ-006 data_we_i  input  1  1 = write, 0 = read.
REQ-007 data_be_i  input  4  byte enables.
REQ-008 data_addr_i  input  32  byte address.
REQ-009 data_wdata_i  input  32  write data.
REQ-010 data_rvalid_o  output  1  one-cycle response strobe.
REQ-011 data_rdata_o  output  32  read data, valid with data_rvalid_o.
REQ-012 data_err_o  output  1  bus error or timeout, valid with data_rvalid_o.
REQ-013 wb_cyc / wb_stb / wb_we  output  1 each  Wishbone pipelined-mode master controls.
REQ-014 wb_addr  output  32;  wb_data  output  32 (write data);  wb_be  output  4.
REQ-015 wb_rdata  input  32;  wb_ack  input  1;  wb_err  input  1;  wb_stall  input  1.

Function
REQ-016 FSM states IDLE, REQ, WAIT, RESP; exactly one transaction outstanding at any time.
REQ-017 IDLE: data_gnt_o = data_req_i combinationally; on gnt, capture we/be/addr/wdata into registers, clear timer, go to REQ.
REQ-018 data_gnt_o SHALL be 0 in REQ, WAIT, RESP.
REQ-019 REQ: wb_cyc=1, wb_stb=1, wb_addr/wb_data/wb_be/wb_we from capture registers, held stable while wb_stall=1.
REQ-020 REQ with wb_stall=0 and (wb_ack|wb_err)=1: accept and complete same cycle, go to RESP.
REQ-021 REQ with wb_stall=0 and no ack/err: go to WAIT.
REQ-022 WAIT: wb_cyc=1, wb_stb=0; on wb_ack or wb_err go to RESP.
REQ-023 wb_ack/wb_err SHALL be ignored in IDLE and RESP.
REQ-024 On completion capture wb_rdata (reads only; writes capture 0) and err = wb_err & ~wb_ack.
REQ-025 Timer counts every cycle in REQ and WAIT; when it equals TIMEOUT_CYCLES-1 with no ack/err, go to RESP with err=1, rdata=0.
REQ-026 Ack or err in the timeout cycle takes priority over timeout.
REQ-027 RESP: wb_cyc=0, wb_stb=0; data_rvalid_o=1 for exactly one cycle with captured rdata/err; go to IDLE.
REQ-028 data_rdata_o and data_err_o SHALL be 0 whenever data_rvalid_o=0.
REQ-029 Minimum throughput: one transaction per 3 cycles (IDLE-REQ-RESP); latency gnt to rvalid = 2 cycles with zero stall and immediate ack.

Reset
REQ-030 While rst=1: state IDLE, timer 0, capture registers 0, every output 0 except data_gnt_o, which is 0 while rst=1.
REQ-031 rst asserted mid-transaction (REQ or WAIT) drops wb_cyc/wb_stb immediately (asynchronously); no data_rvalid_o is generated for the aborted request.

Verification
REQ-032 Read, no stall: req addr 0x1000; slave ack next cycle with rdata 0xDEADBEEF -> gnt cycle 0, stb cycle 1, rvalid cycle 3 with rdata 0xDEADBEEF, err 0.
REQ-033 Write with 3 stall cycles: addr 0x2004, be 0x3, wdata 0x12345678 -> wb_stb high 4 cycles with constant addr/data/be; one rvalid, rdata 0.
REQ-034 Slave wb_err on read -> rvalid with err=1, rdata 0; next req granted the cycle after rvalid.
REQ-035 TIMEOUT_CYCLES=8, slave never acks -> wb_cyc high exactly 8 cycles, then rvalid with err=1.
REQ-036 Back-to-back requests with data_req_i held high -> gnt only in IDLE, never two outstanding, one rvalid per gnt.
REQ-037 rst pulsed while in WAIT -> wb_cyc 0 same cycle, no rvalid; subsequent read completes normally.

Source files
------------

// File: rtl/ibex_wb_bridge.sv
// rtl/ibex_wb_bridge.sv - Ibex LSU to Wishbone pipelined-mode master bridge
//
// Purpose:
//   Converts single Ibex data-port transactions into Wishbone pipelined
//   cycles. Only one transaction is outstanding at a time. A cycle that is
//   held open for TIMEOUT_CYCLES cycles without ack/err is completed
//   with an error.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   data_req_i/data_gnt_o    Ibex request / grant (grant only in IDLE)
//   data_we_i, data_be_i     write enable, byte enables
//   data_addr_i, data_wdata_i  byte address, write data
//   data_rvalid_o            one-cycle response strobe
//   data_rdata_o, data_err_o response data / error, zero when no rvalid
//   wb_cyc, wb_stb, wb_we    Wishbone master controls
//   wb_addr, wb_data, wb_be  Wishbone address, write data, byte enables
//   wb_rdata, wb_ack, wb_err, wb_stall  Wishbone slave responses

module ibex_wb_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic        wb_cyc,
  output logic        wb_stb,
  output logic        wb_we,
  output logic [31:0] wb_addr,
  output logic [31:0] wb_data,
  output logic [3:0]  wb_be,
  input  logic [31:0] wb_rdata,
  input  logic        wb_ack,
  input  logic        wb_err,
  input  logic        wb_stall
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_timer;
  logic        r_we;
  logic [3:0]  r_be;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_err;

  logic        w_gnt;
  logic        w_done;     // slave completed the transaction this cycle
  logic        w_tmo;      // timer expired without a slave response
  logic        w_resp;     // ack or err seen on the bus

  assign w_resp = wb_ack | wb_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next        = r_state;
    w_gnt         = 1'b0;
    w_done        = 1'b0;
    w_tmo         = 1'b0;
    wb_cyc        = 1'b0;
    wb_stb        = 1'b0;
    data_rvalid_o = 1'b0;
    data_rdata_o  = 32'h0;
    data_err_o    = 1'b0;
    case (r_state)
      IDLE: begin
        // Grant is masked by rst so nothing is accepted while in reset.
        w_gnt = data_req_i & ~rst;
        if (w_gnt) begin
          w_next = REQ;
        end
      end
      REQ: begin
        wb_cyc = 1'b1;
        wb_stb = 1'b1;
        // A response only counts once the strobe has been accepted.
        if (!wb_stall && w_resp) begin
          w_done = 1'b1;
          w_next = RESP;
        end else if (r_timer == TMO_LAST) begin
          w_tmo  = 1'b1;
          w_next = RESP;
        end else if (!wb_stall) begin
          w_next = WAIT;
        end
      end
      WAIT: begin
        wb_cyc = 1'b1;
        if (w_resp) begin
          w_done = 1'b1;
          w_next = RESP;
        end else if (r_timer == TMO_LAST) begin
          w_tmo  = 1'b1;
          w_next = RESP;
        end
      end
      RESP: begin
        data_rvalid_o = 1'b1;
        data_rdata_o  = r_rdata;
        data_err_o    = r_err;
        w_next        = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign data_gnt_o = w_gnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_timer <= 16'h0;
      r_we    <= 1'b0;
      r_be    <= 4'h0;
      r_addr  <= 32'h0;
      r_wdata <= 32'h0;
      r_rdata <= 32'h0;
      r_err   <= 1'b0;
    end else begin
      if (w_gnt) begin
        r_we    <= data_we_i;
        r_be    <= data_be_i;
        r_addr  <= data_addr_i;
        r_wdata <= data_wdata_i;
        r_timer <= 16'h0;
      end else if (r_state == REQ || r_state == WAIT) begin
        r_timer <= r_timer + 16'd1;
      end

      if (w_done) begin
        // Ack wins over a simultaneous err; error responses carry no data.
        r_rdata <= (!r_we && wb_ack) ? wb_rdata : 32'h0;
        r_err   <= wb_err & ~wb_ack;
      end else if (w_tmo) begin
        r_rdata <= 32'h0;
        r_err   <= 1'b1;
      end
    end
  end

  assign wb_we   = r_we;
  assign wb_be   = r_be;
  assign wb_addr = r_addr;
  assign wb_data = r_wdata;

endmodule

// File: tb/tb_ibex_wb_bridge.sv
// tb/tb_ibex_wb_bridge.sv - directed self-checking bench for ibex_wb_bridge

module tb_ibex_wb_bridge;

  logic        clk;
  logic        rst;
  logic        req;
  logic        gnt;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err_o;
  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_we;
  logic [31:0] wb_addr;
  logic [31:0] wb_data;
  logic [3:0]  wb_be;
  logic [31:0] wb_rdata;
  logic        wb_ack;
  logic        wb_err;
  logic        wb_stall;

  int n_cmp;
  int n_bad;

  ibex_wb_bridge #(.TIMEOUT_CYCLES(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .data_req_i   (req),
    .data_gnt_o   (gnt),
    .data_we_i    (we),
    .data_be_i    (be),
    .data_addr_i  (addr),
    .data_wdata_i (wdata),
    .data_rvalid_o(rvalid),
    .data_rdata_o (rdata),
    .data_err_o   (err_o),
    .wb_cyc       (wb_cyc),
    .wb_stb       (wb_stb),
    .wb_we        (wb_we),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .wb_be        (wb_be),
    .wb_rdata     (wb_rdata),
    .wb_ack       (wb_ack),
    .wb_err       (wb_err),
    .wb_stall     (wb_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    rst      = 1'b1;
    req      = 1'b1;
    we       = 1'b0;
    be       = 4'h0;
    addr     = 32'h0;
    wdata    = 32'h0;
    wb_rdata = 32'h0;
    wb_ack   = 1'b0;
    wb_err   = 1'b0;
    wb_stall = 1'b0;

    // Reset state, request held high during reset must not be granted
    nxt;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_cyc", 32'(wb_cyc), 32'd0);
    chk("rst_stb", 32'(wb_stb), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_addr", wb_addr, 32'h0);
    nxt;
    rst = 1'b0;
    req = 1'b0;
    #1;
    chk("idle_gnt", 32'(gnt), 32'd0);

    // Read, ack one cycle after the strobe: gnt c0, stb c1, rvalid c3
    nxt;
    req = 1'b1; we = 1'b0; addr = 32'h0000_1000; be = 4'hF;
    #1;
    chk("rd_gnt", 32'(gnt), 32'd1);
    nxt;
    req = 1'b0; addr = 32'hFFFF_0000; be = 4'h0;
    #1;
    chk("rd_stb", 32'(wb_stb), 32'd1);
    chk("rd_addr", wb_addr, 32'h0000_1000);
    chk("rd_be", 32'(wb_be), 32'hF);
    chk("rd_we", 32'(wb_we), 32'd0);
    chk("rd_gnt_req", 32'(gnt), 32'd0);
    nxt;
    wb_ack = 1'b1; wb_rdata = 32'hDEAD_BEEF;
    #1;
    chk("rd_wait_stb", 32'(wb_stb), 32'd0);
    chk("rd_wait_cyc", 32'(wb_cyc), 32'd1);
    chk("rd_wait_rvalid", 32'(rvalid), 32'd0);
    nxt;
    wb_ack = 1'b0; wb_rdata = 32'h5555_5555;
    #1;
    chk("rd_rvalid", 32'(rvalid), 32'd1);
    chk("rd_rdata", rdata, 32'hDEAD_BEEF);
    chk("rd_err", 32'(err_o), 32'd0);
    chk("rd_resp_cyc", 32'(wb_cyc), 32'd0);
    nxt;
    #1;
    chk("rd_after_rvalid", 32'(rvalid), 32'd0);
    chk("rd_after_rdata", rdata, 32'h0);

    // Write with three stall cycles: strobe held four cycles, stable payload
    req = 1'b1; we = 1'b1; addr = 32'h0000_2004; be = 4'h3; wdata = 32'h1234_5678;
    wb_stall = 1'b1;
    #1;
    chk("wr_gnt", 32'(gnt), 32'd1);
    nxt;
    req = 1'b0; we = 1'b0; addr = 32'h0; be = 4'h0; wdata = 32'h0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("wr_stall_stb", 32'(wb_stb), 32'd1);
      chk("wr_stall_addr", wb_addr, 32'h0000_2004);
      chk("wr_stall_data", wb_data, 32'h1234_5678);
      chk("wr_stall_be", 32'(wb_be), 32'h3);
      chk("wr_stall_we", 32'(wb_we), 32'd1);
      nxt;
    end
    wb_stall = 1'b0; wb_ack = 1'b1; wb_rdata = 32'hFFFF_FFFF;
    #1;
    chk("wr_accept_stb", 32'(wb_stb), 32'd1);
    chk("wr_accept_addr", wb_addr, 32'h0000_2004);
    nxt;
    wb_ack = 1'b0;
    #1;
    chk("wr_rvalid", 32'(rvalid), 32'd1);
    chk("wr_rdata", rdata, 32'h0);
    chk("wr_err", 32'(err_o), 32'd0);
    chk("wr_resp_stb", 32'(wb_stb), 32'd0);
    nxt;

    // Slave error on a read, then next request granted right after rvalid
    req = 1'b1; we = 1'b0; addr = 32'h0000_3000; be = 4'hF;
    #1;
    chk("er_gnt", 32'(gnt), 32'd1);
    nxt;
    req = 1'b0; wb_err = 1'b1; wb_rdata = 32'hA5A5_A5A5;
    #1;
    chk("er_stb", 32'(wb_stb), 32'd1);
    nxt;
    wb_err = 1'b0; req = 1'b1; addr = 32'h0000_4000;
    #1;
    chk("er_rvalid", 32'(rvalid), 32'd1);
    chk("er_err", 32'(err_o), 32'd1);
    chk("er_rdata", rdata, 32'h0);
    chk("er_resp_gnt", 32'(gnt), 32'd0);
    nxt;
    chk("er_next_gnt", 32'(gnt), 32'd1);

    // Timeout: slave never answers, cyc high exactly 8 cycles
    nxt;
    req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("to_cyc", 32'(wb_cyc), 32'd1);
      chk("to_rvalid", 32'(rvalid), 32'd0);
      nxt;
    end
    #1;
    chk("to_cyc_drop", 32'(wb_cyc), 32'd0);
    chk("to_rvalid_end", 32'(rvalid), 32'd1);
    chk("to_err", 32'(err_o), 32'd1);
    chk("to_rdata", rdata, 32'h0);
    nxt;

    // Back-to-back with req and ack held high: IDLE-REQ-RESP per transfer
    req = 1'b1; wb_ack = 1'b1;
    for (int t = 0; t < 3; t++) begin
      addr = 32'h0000_5000 + 32'(t * 4);
      wb_rdata = 32'h0000_0BAD;
      #1;
      chk("bb_gnt_idle", 32'(gnt), 32'd1);
      chk("bb_rvalid_idle", 32'(rvalid), 32'd0);
      nxt;
      addr = 32'hFFFF_FFF0;
      wb_rdata = 32'hC0DE_0000 | 32'(t);
      #1;
      chk("bb_gnt_req", 32'(gnt), 32'd0);
      chk("bb_stb", 32'(wb_stb), 32'd1);
      chk("bb_addr", wb_addr, 32'h0000_5000 + 32'(t * 4));
      nxt;
      wb_rdata = 32'h0000_0BAD;
      #1;
      chk("bb_gnt_resp", 32'(gnt), 32'd0);
      chk("bb_rvalid", 32'(rvalid), 32'd1);
      chk("bb_rdata", rdata, 32'hC0DE_0000 | 32'(t));
      nxt;
    end
    req = 1'b0; wb_ack = 1'b0;

    // Reset pulse while in WAIT: cyc drops at once, no response afterwards
    req = 1'b1; addr = 32'h0000_6000;
    #1;
    chk("rw_gnt", 32'(gnt), 32'd1);
    nxt;
    req = 1'b0;
    #1;
    chk("rw_stb", 32'(wb_stb), 32'd1);
    nxt;
    chk("rw_wait_cyc", 32'(wb_cyc), 32'd1);
    rst = 1'b1;
    #1;
    chk("rw_async_cyc", 32'(wb_cyc), 32'd0);
    chk("rw_async_stb", 32'(wb_stb), 32'd0);
    nxt;
    nxt;
    rst = 1'b0; wb_ack = 1'b1;
    #1;
    chk("rw_no_rvalid0", 32'(rvalid), 32'd0);
    nxt;
    wb_ack = 1'b0;
    #1;
    chk("rw_no_rvalid1", 32'(rvalid), 32'd0);
    chk("rw_idle_cyc", 32'(wb_cyc), 32'd0);
    req = 1'b1; addr = 32'h0000_7000;
    #1;
    chk("rw2_gnt", 32'(gnt), 32'd1);
    nxt;
    req = 1'b0; wb_ack = 1'b1; wb_rdata = 32'h0BAD_F00D;
    #1;
    chk("rw2_addr", wb_addr, 32'h0000_7000);
    nxt;
    wb_ack = 1'b0; wb_rdata = 32'h0;
    #1;
    chk("rw2_rvalid", 32'(rvalid), 32'd1);
    chk("rw2_rdata", rdata, 32'h0BAD_F00D);
    chk("rw2_err", 32'(err_o), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
